// File: rtl/atanh_pkg.sv
// Shared types and constants for the atanh request front-end.
package atanh_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  localparam int unsigned CORDIC_LAT = 23;
  localparam int unsigned Q_ONE      = 256;
  localparam int unsigned CLAMP_DEF  = 206;

endpackage

// File: rtl/atanh_dispatch_sync_fifo.sv
// Single-clock FIFO with registered pointers and an occupancy count.
module sync_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned LW = AW + 1;

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  // A full FIFO refuses a push even when a pop frees a slot this cycle.
  assign do_push = push_i & (level_q != LW'(Depth));
  assign do_pop  = pop_i & (level_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem[rptr_q];
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/atanh_dispatch.sv
// Flow-control front-end for one iterative atanh core: clamp, queue, issue, time out, return.
module atanh_dispatch
  import atanh_pkg::*;
#(
  parameter int unsigned DW      = 9,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CLAMP   = CLAMP_DEF,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW-1:0]           out_data,
  output logic                    out_sat,
  output logic                    out_err,
  output logic                    core_trig,
  output logic [DW-1:0]           core_tanha,
  input  logic                    core_vld,
  input  logic [DW-1:0]           core_a,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam logic signed [DW-1:0] CMAX = DW'(CLAMP);
  localparam logic signed [DW-1:0] CMIN = -CMAX;

  logic signed [DW-1:0] din, din_clamp;
  logic                 din_sat;

  always_comb begin
    din       = $signed(in_data);
    din_clamp = din;
    din_sat   = 1'b0;
    if (din > CMAX) begin
      din_clamp = CMAX;
      din_sat   = 1'b1;
    end else if (din < CMIN) begin
      din_clamp = CMIN;
      din_sat   = 1'b1;
    end
  end

  logic          fifo_push, fifo_pop, fifo_empty;
  logic [DW:0]   fifo_rdata;
  logic [LW-1:0] fifo_level, level_next;
  state_t        state;
  logic          sat_r;
  logic [TW-1:0] tmo_cnt;

  assign fifo_push  = in_valid & in_ready;
  assign fifo_pop   = (state == IDLE) & ~fifo_empty & ~out_valid;
  assign level_next = fifo_level + LW'(fifo_push) - LW'(fifo_pop);
  assign level      = fifo_level;
  assign busy       = (state != IDLE) | ~fifo_empty;

  sync_fifo #(
    .Width (DW + 1),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i ({din_sat, din_clamp}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Registered so in_ready stays low throughout reset and rises on the first free cycle.
  always_ff @(posedge clk) begin
    if (rst) in_ready <= 1'b0;
    else     in_ready <= (level_next < LW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      core_trig  <= 1'b0;
      core_tanha <= '0;
      sat_r      <= 1'b0;
      tmo_cnt    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sat    <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fifo_pop) begin
            core_tanha <= fifo_rdata[DW-1:0];
            sat_r      <= fifo_rdata[DW];
            core_trig  <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          core_trig <= 1'b0;
          tmo_cnt   <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (core_vld) begin
            out_data  <= core_a;
            out_sat   <= sat_r;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            out_data  <= '0;
            out_sat   <= sat_r;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atanh_dispatch.sv
// Scoreboard bench for atanh_dispatch with a fixed-latency core stub (core_a = core_tanha + 1).
module tb_atanh_dispatch;
  import atanh_pkg::*;

  localparam int DW      = 9;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 32;
  localparam int CLAMP   = 206;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data, core_tanha, core_a;
  logic          out_sat, out_err, core_trig, core_vld, busy;
  logic [2:0]    level;

  always #5 clk = ~clk;

  atanh_dispatch #(
    .DW      (DW),
    .DEPTH   (DEPTH),
    .CLAMP   (CLAMP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .out_err    (out_err),
    .core_trig  (core_trig),
    .core_tanha (core_tanha),
    .core_vld   (core_vld),
    .core_a     (core_a),
    .busy       (busy),
    .level      (level)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Core stub: counter started by trig, vld when it reaches stub_lat.
  int stub_cnt = 0;
  int stub_lat = CORDIC_LAT;
  assign core_vld = (stub_cnt == stub_lat);
  assign core_a   = core_tanha + 9'd1;

  always @(posedge clk) begin
    if (core_trig)          stub_cnt <= 1;
    else if (stub_cnt != 0) stub_cnt <= (stub_cnt >= stub_lat) ? 0 : stub_cnt + 1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    int sat;
    int err;
  } exp_t;

  exp_t res_q[$];
  int   tanha_q[$];

  int   n_out = 0, trig_cnt = 0, vld_seen = 0;
  int   last_trig_cyc = 0, ov_rise_cyc = 0;
  logic ov_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      ov_prev <= out_valid;
      if (out_valid && !ov_prev) ov_rise_cyc <= cyc;
      if (core_vld) vld_seen <= vld_seen + 1;
      if (core_trig) begin
        trig_cnt      <= trig_cnt + 1;
        last_trig_cyc <= cyc;
        if (tanha_q.size() == 0) check("unexpected_trig", 1, 0);
        else check("core_tanha", $signed(core_tanha), tanha_q.pop_front());
      end
      if (out_valid && out_ready) begin
        n_out <= n_out + 1;
        if (res_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = res_q.pop_front();
          check("out_data", $signed(out_data), e.data);
          check("out_err", int'(out_err), e.err);
          if (e.err == 0) check("out_sat", int'(out_sat), e.sat);
        end
      end
    end
  end

  function automatic int clampv(input int v);
    return (v > CLAMP) ? CLAMP : ((v < -CLAMP) ? -CLAMP : v);
  endfunction

  task automatic enqueue(input int v, input int tmo);
    exp_t e;
    int   c;
    c      = clampv(v);
    e.sat  = (c != v) ? 1 : 0;
    e.err  = tmo;
    e.data = tmo ? 0 : c + 1;
    res_q.push_back(e);
    tanha_q.push_back(c);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push_one(input int v, input int tmo);
    int n = 0;
    in_data  = DW'(v);
    in_valid = 1'b1;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("push_accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      enqueue(v, tmo);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((res_q.size() != 0 || busy || out_valid) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (res_q.size() != 0 || busy || out_valid) check("drain_timeout", 0, 1);
  endtask

  task automatic wait_out_valid(input int max);
    int n = 0;
    while (!out_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic wait_vld_after(input int v0, input int max);
    int n = 0;
    while (vld_seen <= v0 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (vld_seen <= v0) check("stale_vld_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, v0, acc, t_trig, n0;
    logic [DW+1:0] held;
    logic stable;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_level", int'(level), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_core_trig", int'(core_trig), 0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", int'(in_ready), 1);

    // Single request latency
    out_ready = 1'b1;
    t0 = cyc;
    push_one(128, 0);
    wait_drain(100);
    check("trig_latency", last_trig_cyc - t0, 2);
    check("out_valid_latency", ov_rise_cyc - t0, 26);

    // Clamp boundaries
    push_one(255, 0);
    push_one(-256, 0);
    push_one(206, 0);
    push_one(-206, 0);
    push_one(-100, 0);
    wait_drain(400);

    // Hold with a full FIFO behind it
    out_ready = 1'b0;
    n0 = n_out;
    push_one(10, 0);
    wait_out_valid(60);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(20 + i);
      if (in_ready) begin
        enqueue(20 + i, 0);
        acc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, 4);
    check("bp_level", int'(level), 4);
    check("bp_in_ready", int'(in_ready), 0);
    held   = {out_err, out_sat, out_data};
    t_trig = trig_cnt;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || {out_err, out_sat, out_data} != held) stable = 1'b0;
    end
    check("hold_stable", int'(stable), 1);
    check("hold_no_trig", trig_cnt, t_trig);
    out_ready = 1'b1;
    wait_drain(400);
    check("bp_results", n_out - n0, 5);

    // Timeout, then a late strobe that must be ignored
    out_ready = 1'b1;
    stub_lat  = 40;
    v0 = vld_seen;
    push_one(50, 1);
    wait_drain(100);
    check("timeout_latency", ov_rise_cyc - last_trig_cyc, TIMEOUT + 1);
    wait_vld_after(v0, 60);
    @(negedge clk);
    check("late_vld_no_out", int'(out_valid), 0);
    stub_lat = CORDIC_LAT;
    push_one(-60, 0);
    wait_drain(100);

    // Reset while waiting with three queued
    v0 = vld_seen;
    for (int i = 0; i < 4; i++) push_one(70 + i, 0);
    repeat (3) @(negedge clk);
    check("pre_rst_level", int'(level), 3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    res_q.delete();
    tanha_q.delete();
    check("mid_rst_level", int'(level), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    rst = 1'b0;
    wait_vld_after(v0, 60);
    @(negedge clk);
    check("stale_vld_no_out", int'(out_valid), 0);
    check("stale_vld_idle", int'(busy), 0);
    push_one(90, 0);
    wait_drain(100);

    check("total_results", n_out, 14);
    check("scoreboard_empty", res_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
